present_dec: RTL and testbench
==============================

# present_dec

PRESENT-80 block-cipher decryption core; the inverse counterpart of the encryption datapath (S-layer `p` permutation round). Accepts a 64-bit ciphertext and 80-bit key on a start pulse. Derives round key K32 by running the forward key schedule, then performs 31 iterative inverse rounds, one per clock. Returns the 64-bit plaintext with a one-cycle done pulse.

## Interface
- No parameters. Round count 31 and the S-box tables are fixed constants in the package.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request. Sampled only while `busy`=0.
- `state` in 64: ciphertext. Captured on the accepted `start` edge.
- `keys` in 80: user key K[79:0]. Captured on the accepted `start` edge.
- `busy` out 1: high from the cycle after acceptance until `done`.
- `done` out 1: one-cycle pulse; `result` is valid from this cycle.
- `result` out 64: plaintext. Held until the next accepted `start`.

## Operation
- FSM states: IDLE, KEYEXP, WHITEN, ROUND, FIN.
- **IDLE**
  - If `start`=1: load `cnt`=1, key register from `keys`, data register from `state`; go to KEYEXP.
  - `start` while busy is ignored; there is no queueing.
- **KEYEXP** (31 cycles, `cnt`=1..31). Forward key update:
  - k = k <<< 61
  - k[79:76] = S(k[79:76])
  - k[19:15] ^= cnt
  - `cnt`++. After `cnt`=31: go to WHITEN.
  - The key register now holds K32 state.
- **WHITEN**
  - data ^= k[79:16]
  - `cnt`=31; go to ROUND.
- **ROUND** (31 cycles, `cnt`=31 down to 1), evaluated in this order within one cycle:
  - data = invS(invP(data)), applied per nibble.
  - Inverse key update: k[19:15] ^= cnt; k[79:76] = invS(k[79:76]); k = k >>> 61.
  - data ^= new k[79:16].
  - `cnt`--. After `cnt`=1: go to FIN.
- **FIN**
  - `result` = data; `done`=1 for one cycle; `busy`=0; go to IDLE.
  - A `start` in the FIN cycle is not accepted.
- **Permutation rules**
  - P maps bit i to bit (16·i) mod 63, with bit 63 fixed.
  - invP maps bit j to bit (4·j) mod 63, with bit 63 fixed.
- **Tables**
  - S = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
  - invS = 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A
- **Width rules**
  - `cnt` is 5 bits and never wraps; 0 is unused.
  - All other arithmetic is bitwise.

## Timing
- Reset (`rst_n`=0 at an edge) gives: FSM=IDLE, `busy`=0, `done`=0, `result`=0, data/key/`cnt` cleared.
- Reset mid-operation aborts at once. No `done` is produced for the aborted request.
- Latency: `start` accepted at edge E0, then `done`=1 during the cycle after edge E64.
  - E1–E31: KEYEXP.
  - E32: WHITEN.
  - E33–E63: ROUND.
  - E64: FIN.
- Throughput: one block per 65 cycles. The next `start` is accepted at the earliest in the cycle after `done`.
- `result` changes only at the FIN edge. `busy` and `done` are never high together.

## Structure
- `present_pkg` holds:
  - `ROUNDS`=31
  - S and invS functions (4→4)
  - P and invP functions (64→64)
  - FSM state typedef
- One sub-module, `present_key_sched`:
  - 80-bit register with synchronous load.
  - Modes: forward step / inverse step / hold.
  - Inputs: `cnt`, mode.
  - Output: round key `k[79:16]`.
- The top level holds the FSM, the data register and the round logic.

## Test plan
- key 0, ct 5579C1387B228445 → `result` 0000000000000000; `done` exactly 64 edges after `start`.
- key FFFF…FF (80b), ct E72C46C0F5945049 → `result` 0000000000000000.
- key 0, ct A112FFC72F68417B → `result` FFFFFFFFFFFFFFFF.
- key FFFF…FF, ct 3333DCD3213210D2 → `result` FFFFFFFFFFFFFFFF.
- `start` held high through a whole operation, with `state`/`keys` changed mid-run → result unaffected. A second operation starts only after `done`, and its latency is again 64.
- `rst_n` low at cycle 20 of a run → outputs zero and `busy`=0 next cycle, no `done`. A fresh `start` then gives the correct result.

Source files
------------

// File: rtl/present_pkg.sv
// Shared constants, S-box / permutation helpers and FSM types for the PRESENT-80 decryptor.
package present_pkg;

    localparam logic [4:0]  ROUNDS       = 5'd31;
    localparam logic [63:0] SBOX_TBL     = 64'h21748FE3DA09B65C;
    localparam logic [63:0] INV_SBOX_TBL = 64'hA970364BD21C8FE5;

    typedef enum logic [2:0] {StIdle, StKeyexp, StWhiten, StRound, StFin} fsm_e;
    typedef enum logic [1:0] {KsHold, KsFwd, KsInv} ks_mode_e;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_TBL[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        return INV_SBOX_TBL[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] d);
        logic [63:0] r;
        r[63] = d[63];
        for (int i = 0; i < 63; i++) r[(16 * i) % 63] = d[i];
        return r;
    endfunction

    function automatic logic [63:0] inv_p_layer(input logic [63:0] d);
        logic [63:0] r;
        r[63] = d[63];
        for (int j = 0; j < 63; j++) r[(4 * j) % 63] = d[j];
        return r;
    endfunction

    function automatic logic [63:0] inv_s_layer(input logic [63:0] d);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) r[4 * n +: 4] = inv_sbox(d[4 * n +: 4]);
        return r;
    endfunction

endpackage

// File: rtl/present_key_sched.sv
// PRESENT-80 key register with forward (encrypt) and inverse (decrypt) update steps.
module present_key_sched
    import present_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [79:0] load_key,
    input  ks_mode_e    mode,
    input  logic [4:0]  cnt,
    output logic [63:0] round_key
);

    logic [79:0] k_q;
    logic [79:0] k_d;
    logic [79:0] t;

    always_comb begin
        k_d = k_q;
        t   = k_q;
        case (mode)
            KsFwd: begin
                t          = {k_q[18:0], k_q[79:19]};
                t[79:76]   = sbox(t[79:76]);
                t[19:15]   = t[19:15] ^ cnt;
                k_d        = t;
            end
            KsInv: begin
                t[19:15]   = t[19:15] ^ cnt;
                t[79:76]   = inv_sbox(t[79:76]);
                k_d        = {t[60:0], t[79:61]};
            end
            default: k_d = k_q;
        endcase
    end

    // Next-state view: in an inverse step this is already the key for the current round.
    assign round_key = k_d[79:16];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q <= '0;
        end else if (load) begin
            k_q <= load_key;
        end else begin
            k_q <= k_d;
        end
    end

endmodule

// File: rtl/present_dec.sv
// PRESENT-80 decryption core: forward key expansion to K32, then 31 inverse rounds.
module present_dec
    import present_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] state,
    input  logic [79:0] keys,
    output logic        busy,
    output logic        done,
    output logic [63:0] result
);

    fsm_e        fsm;
    logic [4:0]  cnt;
    logic [63:0] data;
    logic [63:0] round_key;
    ks_mode_e    ks_mode;
    logic        ks_load;

    always_comb begin
        ks_load = (fsm == StIdle) && start;
        case (fsm)
            StKeyexp: ks_mode = KsFwd;
            StRound:  ks_mode = KsInv;
            default:  ks_mode = KsHold;
        endcase
    end

    present_key_sched u_key_sched (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ks_load),
        .load_key  (keys),
        .mode      (ks_mode),
        .cnt       (cnt),
        .round_key (round_key)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm    <= StIdle;
            cnt    <= '0;
            data   <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                StIdle: begin
                    if (start) begin
                        cnt  <= 5'd1;
                        data <= state;
                        busy <= 1'b1;
                        fsm  <= StKeyexp;
                    end
                end
                StKeyexp: begin
                    if (cnt == ROUNDS) fsm <= StWhiten;
                    else               cnt <= cnt + 5'd1;
                end
                StWhiten: begin
                    data <= data ^ round_key;
                    cnt  <= ROUNDS;
                    fsm  <= StRound;
                end
                StRound: begin
                    data <= inv_s_layer(inv_p_layer(data)) ^ round_key;
                    if (cnt == 5'd1) fsm <= StFin;
                    else             cnt <= cnt - 5'd1;
                end
                StFin: begin
                    result <= data;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    fsm    <= StIdle;
                end
                default: fsm <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_present_dec.sv
// Vector-table and scoreboard bench for present_dec, including held-start and reset-abort runs.
module tb_present_dec;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] state;
    logic [79:0] keys;
    logic        busy;
    logic        done;
    logic [63:0] result;

    typedef struct {
        logic [79:0] key;
        logic [63:0] ct;
        logic [63:0] pt;
    } vec_t;

    typedef struct {
        logic [63:0] pt;
        int          done_cyc;
    } exp_t;

    vec_t vecs[4];
    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    present_dec dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .state  (state),
        .keys   (keys),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            check("busy low during done", 80'(busy), 80'd0);
            if (sb.size() == 0) begin
                check("unexpected done", 80'(done), 80'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 80'(result), 80'(e.pt));
                check("done latency", 80'(cyc), 80'(e.done_cyc));
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard drained", 80'(sb.size()), 80'd0);
    endtask

    task automatic do_op(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        state = v.ct;
        keys  = v.key;
        start = 1'b1;
        // Accepted at the next edge; done visible after 64 further edges.
        e.pt       = v.pt;
        e.done_cyc = cyc + 65;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy after accept", 80'(busy), 80'd1);
        wait_idle(100);
    endtask

    initial begin
        exp_t e;
        int   base;
        vecs[0] = '{key: 80'h0, ct: 64'h5579C1387B228445, pt: 64'h0000000000000000};
        vecs[1] = '{key: {80{1'b1}}, ct: 64'hE72C46C0F5945049, pt: 64'h0000000000000000};
        vecs[2] = '{key: 80'h0, ct: 64'hA112FFC72F68417B, pt: 64'hFFFFFFFFFFFFFFFF};
        vecs[3] = '{key: {80{1'b1}}, ct: 64'h3333DCD3213210D2, pt: 64'hFFFFFFFFFFFFFFFF};

        rst_n = 1'b0;
        start = 1'b0;
        state = '0;
        keys  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 80'(busy), 80'd0);
        check("reset done", 80'(done), 80'd0);
        check("reset result", 80'(result), 80'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) do_op(vecs[i]);

        // start held through a run with inputs scrambled; second op begins only after done.
        @(posedge clk);
        #1;
        state = vecs[0].ct;
        keys  = vecs[0].key;
        start = 1'b1;
        base  = cyc;
        e.pt = vecs[0].pt; e.done_cyc = base + 65;  sb.push_back(e);
        e.pt = vecs[2].pt; e.done_cyc = base + 130; sb.push_back(e);
        @(posedge clk);
        repeat (15) @(posedge clk);
        #1;
        state = {$urandom, $urandom};
        keys  = {16'($urandom), $urandom, $urandom};
        repeat (20) @(posedge clk);
        #1;
        state = vecs[2].ct;
        keys  = vecs[2].key;
        repeat (30) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(200);

        // Reset in the middle of a run aborts it without a done.
        @(posedge clk);
        #1;
        state = vecs[1].ct;
        keys  = vecs[1].key;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("busy mid-run", 80'(busy), 80'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort busy", 80'(busy), 80'd0);
        check("abort done", 80'(done), 80'd0);
        check("abort result", 80'(result), 80'd0);
        rst_n = 1'b1;
        repeat (80) @(posedge clk);
        do_op(vecs[3]);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
